// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: owns the framebuffer write port. It arbitrates round-robin
// between two pixel requesters and contains a full-frame clear engine.
// Optional feature macro: FB_ARB_STATS_EN enables the grant/stall statistic counters.
// ADDR_W corresponds to DISP_ADDR_WIDTH (memory/memory_sizes.vh); override at instantiation.
module fb_write_arbiter #(
    parameter int unsigned FB_PIXELS = 76800,
    parameter int unsigned ADDR_W    = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_start,
    input  logic [11:0]       clear_colour,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [11:0]       req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [11:0]       req1_data,
    output logic              req1_ready,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [31:0]       fb_wdata,
    output logic [31:0]       stat_grant0,
    output logic [31:0]       stat_grant1,
    output logic [31:0]       stat_stall
);

    localparam int unsigned PAD_W = 20;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [11:0]       colour_q;
    logic              fb_we_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [31:0]       fb_wdata_q;
    logic              clear_busy_q;
    logic              clear_done_q;
    logic              grant0_c;
    logic              grant1_c;

    // Grant decision: requesters are only served in ARB and never in the clear-accept cycle.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (state_q == ST_ARB && !clear_start) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q) begin
                    grant0_c = 1'b1;
                end else begin
                    grant1_c = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_c = 1'b1;
            end else if (req1_valid) begin
                grant1_c = 1'b1;
            end
        end
    end

    assign req0_ready = grant0_c;
    assign req1_ready = grant1_c;

    // Control FSM with registered write port; last_grant only moves on contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ARB;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            colour_q     <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_wdata_q   <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            fb_we_q      <= 1'b0;
            clear_done_q <= 1'b0;
            case (state_q)
                ST_ARB: begin
                    if (clear_start) begin
                        state_q      <= ST_CLEAR;
                        colour_q     <= clear_colour;
                        cnt_q        <= '0;
                        clear_busy_q <= 1'b1;
                    end else if (grant0_c) begin
                        fb_we_q    <= 1'b1;
                        fb_addr_q  <= req0_addr;
                        fb_wdata_q <= {PAD_W'(0), req0_data};
                        if (req1_valid) begin
                            last_grant_q <= 1'b0;
                        end
                    end else if (grant1_c) begin
                        fb_we_q    <= 1'b1;
                        fb_addr_q  <= req1_addr;
                        fb_wdata_q <= {PAD_W'(0), req1_data};
                        if (req0_valid) begin
                            last_grant_q <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    fb_we_q    <= 1'b1;
                    fb_addr_q  <= cnt_q;
                    fb_wdata_q <= {PAD_W'(0), colour_q};
                    if (cnt_q == LAST_ADDR) begin
                        cnt_q        <= '0;
                        state_q      <= ST_ARB;
                        clear_busy_q <= 1'b0;
                        clear_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;

`ifdef FB_ARB_STATS_EN
    logic [31:0] stat_grant0_q;
    logic [31:0] stat_grant1_q;
    logic [31:0] stat_stall_q;

    // Statistics: grants per requester and cycles with at least one waiting requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grant0_q <= '0;
            stat_grant1_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (req0_valid && grant0_c) begin
                stat_grant0_q <= stat_grant0_q + 32'd1;
            end
            if (req1_valid && grant1_c) begin
                stat_grant1_q <= stat_grant1_q + 32'd1;
            end
            if ((req0_valid && !grant0_c) || (req1_valid && !grant1_c)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_grant0 = stat_grant0_q;
    assign stat_grant1 = stat_grant1_q;
    assign stat_stall  = stat_stall_q;
`else
    assign stat_grant0 = '0;
    assign stat_grant1 = '0;
    assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a 16-pixel framebuffer.
module tb_fb_write_arbiter;

    localparam int unsigned NPIX = 16;
    localparam int unsigned AW   = 17;
    localparam int unsigned NVEC = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_start;
    logic [11:0]   clear_colour;
    logic          clear_busy;
    logic          clear_done;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [11:0]   req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [11:0]   req1_data;
    logic          req1_ready;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [31:0]   fb_wdata;
    logic [31:0]   stat_grant0;
    logic [31:0]   stat_grant1;
    logic [31:0]   stat_stall;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference statistic counts derived from the expected grants.
    int m_g0 = 0;
    int m_g1 = 0;
    int m_st = 0;

    always #5 clk = ~clk;

    fb_write_arbiter #(.FB_PIXELS(NPIX), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_wdata     (fb_wdata),
        .stat_grant0  (stat_grant0),
        .stat_grant1  (stat_grant1),
        .stat_stall   (stat_stall)
    );

    typedef struct {
        logic          r0v;
        logic [AW-1:0] r0a;
        logic [11:0]   r0d;
        logic          r1v;
        logic [AW-1:0] r1a;
        logic [11:0]   r1d;
        logic          e0;
        logic          e1;
        logic          ewe;
        logic [AW-1:0] eaddr;
        logic [31:0]   edata;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Update the statistics model for one cycle given valids and expected readys.
    task automatic model_cycle(input logic v0, input logic v1, input logic e0, input logic e1);
        if (v0 && e0) m_g0++;
        if (v1 && e1) m_g1++;
        if ((v0 && !e0) || (v1 && !e1)) m_st++;
    endtask

    task automatic chk_stats(input string tag);
`ifdef FB_ARB_STATS_EN
        chk({tag, "_grant0"}, stat_grant0, 32'(m_g0));
        chk({tag, "_grant1"}, stat_grant1, 32'(m_g1));
        chk({tag, "_stall"},  stat_stall,  32'(m_st));
`else
        chk({tag, "_grant0"}, stat_grant0, 32'd0);
        chk({tag, "_grant1"}, stat_grant1, 32'd0);
        chk({tag, "_stall"},  stat_stall,  32'd0);
`endif
    endtask

    function automatic vec_t mk(input logic r0v, input logic r1v,
                                input logic e0, input logic e1, input logic ewe,
                                input logic [AW-1:0] eaddr, input logic [31:0] edata);
        vec_t v;
        v.r0v = r0v;  v.r0a = AW'(10); v.r0d = 12'h123;
        v.r1v = r1v;  v.r1a = AW'(20); v.r1d = 12'h456;
        v.e0 = e0; v.e1 = e1; v.ewe = ewe; v.eaddr = eaddr; v.edata = edata;
        return v;
    endfunction

    initial begin
        // Idle, single requester, round-robin, idle hold.
        for (int i = 0; i < 5; i++) vecs[i] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AW'(0), 32'h0);
        vecs[5] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, AW'(5), 32'h0000_0F00);
        vecs[5].r0a = AW'(5);
        vecs[5].r0d = 12'hF00;
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AW'(5),  32'h0000_0F00);
        vecs[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, AW'(10), 32'h0000_0123);
        vecs[8]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, AW'(20), 32'h0000_0456);
        vecs[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, AW'(10), 32'h0000_0123);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, AW'(20), 32'h0000_0456);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AW'(20), 32'h0000_0456);

        reset = 1'b1; clear_start = 1'b0; clear_colour = 12'h0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_we",    32'(fb_we), 32'd0);
        chk("rst_addr",  32'(fb_addr), 32'd0);
        chk("rst_wdata", fb_wdata, 32'd0);
        chk("rst_busy",  32'(clear_busy), 32'd0);
        chk("rst_done",  32'(clear_done), 32'd0);
        chk_stats("rst");

        // Table-driven vectors.
        for (int i = 0; i < int'(NVEC); i++) begin
            req0_valid = vecs[i].r0v; req0_addr = vecs[i].r0a; req0_data = vecs[i].r0d;
            req1_valid = vecs[i].r1v; req1_addr = vecs[i].r1a; req1_data = vecs[i].r1d;
            #1;
            chk($sformatf("v%0d_ready0", i), 32'(req0_ready), 32'(vecs[i].e0));
            chk($sformatf("v%0d_ready1", i), 32'(req1_ready), 32'(vecs[i].e1));
            model_cycle(vecs[i].r0v, vecs[i].r1v, vecs[i].e0, vecs[i].e1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_we", i),    32'(fb_we), 32'(vecs[i].ewe));
            chk($sformatf("v%0d_addr", i),  32'(fb_addr), 32'(vecs[i].eaddr));
            chk($sformatf("v%0d_wdata", i), fb_wdata, vecs[i].edata);
            chk($sformatf("v%0d_busy", i),  32'(clear_busy), 32'd0);
        end
        chk_stats("rr");

        // Full clear with both requesters waiting; a second clear_start at T+5 is ignored.
        req0_valid = 1'b1; req0_addr = AW'(10); req0_data = 12'h123;
        req1_valid = 1'b1; req1_addr = AW'(20); req1_data = 12'h456;
        clear_start = 1'b1; clear_colour = 12'h0A5;
        #1;
        chk("clrT_ready0", 32'(req0_ready), 32'd0);
        chk("clrT_ready1", 32'(req1_ready), 32'd0);
        model_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        clear_colour = 12'hFFF;
        for (int k = 1; k <= int'(NPIX); k++) begin
            clear_start = (k == 5);
            #1;
            chk($sformatf("clr%0d_busy", k),   32'(clear_busy), 32'd1);
            chk($sformatf("clr%0d_done", k),   32'(clear_done), 32'd0);
            chk($sformatf("clr%0d_ready0", k), 32'(req0_ready), 32'd0);
            chk($sformatf("clr%0d_ready1", k), 32'(req1_ready), 32'd0);
            chk($sformatf("clr%0d_we", k),     32'(fb_we), (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) begin
                chk($sformatf("clr%0d_addr", k),  32'(fb_addr), 32'(k - 2));
                chk($sformatf("clr%0d_wdata", k), fb_wdata, 32'h0000_00A5);
            end
            model_cycle(1'b1, 1'b1, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        clear_start = 1'b0;
        #1;
        chk("clrEnd_done",   32'(clear_done), 32'd1);
        chk("clrEnd_busy",   32'(clear_busy), 32'd0);
        chk("clrEnd_we",     32'(fb_we), 32'd1);
        chk("clrEnd_addr",   32'(fb_addr), 32'(NPIX - 1));
        chk("clrEnd_wdata",  fb_wdata, 32'h0000_00A5);
        chk("clrEnd_ready0", 32'(req0_ready), 32'd1);
        chk("clrEnd_ready1", 32'(req1_ready), 32'd0);
        model_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("postclr_we",    32'(fb_we), 32'd1);
        chk("postclr_addr",  32'(fb_addr), 32'd10);
        chk("postclr_wdata", fb_wdata, 32'h0000_0123);
        chk("postclr_done",  32'(clear_done), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk_stats("clr");

        // Clear aborted by reset at T+8; afterwards req0 must win the first tie.
        clear_start = 1'b1; clear_colour = 12'h05A;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_g0 = 0; m_g1 = 0; m_st = 0;
        chk("abort_we",    32'(fb_we), 32'd0);
        chk("abort_busy",  32'(clear_busy), 32'd0);
        chk("abort_addr",  32'(fb_addr), 32'd0);
        chk("abort_wdata", fb_wdata, 32'd0);
        #1;
        chk("abort_ready0", 32'(req0_ready), 32'd1);
        chk("abort_ready1", 32'(req1_ready), 32'd0);
        model_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("abort_we1",   32'(fb_we), 32'd1);
        chk("abort_addr1", 32'(fb_addr), 32'd10);
        chk("abort_r1",    32'(req1_ready), 32'd1);
        model_cycle(1'b1, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("abort_addr2",  32'(fb_addr), 32'd20);
        chk("abort_wdata2", fb_wdata, 32'h0000_0456);
        @(posedge clk); #1;
        chk("abort_idle_we", 32'(fb_we), 32'd0);
        chk_stats("abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Owns the single framebuffer write port (port A of the display pipeline).
- Shares it between two pixel requesters: req0 (game board renderer) and req1 (overlay/score/menu renderer). Arbitration is round-robin.
- Contains a built-in clear engine that floods the whole framebuffer with one colour, for example on game start or reset.
- Output is a registered fb_we/fb_addr/fb_wdata stream that goes directly into the framebuffer RAM.

Parameters:
- FB_PIXELS, 76800, number of framebuffer words (320×240); clear covers addresses 0..FB_PIXELS-1
- ADDR_W, `DISP_ADDR_WIDTH (from memory/memory_sizes.vh), framebuffer address width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear_start  in  1  request a full-frame clear (level sampled each cycle)
- clear_colour  in  12  RGB444 fill colour; latched when the clear is accepted
- clear_busy  out  1  high while the clear engine owns the port
- clear_done  out  1  1-cycle pulse after the last clear write is issued
- req0_valid  in  1  requester 0 has a pixel
- req0_addr  in  ADDR_W  requester 0 pixel address
- req0_data  in  12  requester 0 RGB444 colour
- req0_ready  out  1  requester 0 transfer accepted this cycle
- req1_valid / req1_addr / req1_data / req1_ready  as req0, for requester 1
- fb_we  out  1  framebuffer write enable
- fb_addr  out  ADDR_W  framebuffer address
- fb_wdata  out  32  {20'd0, colour}
- stat_grant0, stat_grant1, stat_stall  out  32 each  statistics (see Optional Feature)

Behaviour:
- Reset (synchronous, wins over everything):
  - State ARB; fb_we=0, fb_addr=0, fb_wdata=0.
  - clear_busy=0, clear_done=0; last_grant=1, so req0 wins the first tie.
  - Clear counter=0; stat counters=0.
  - A reset during CLEAR aborts the clear immediately; there is no partial completion.
- States: ARB, CLEAR.
- ARB state, combinational grant logic:
  - clear_start=1: no ready asserted this cycle; the clear is accepted and the next state is CLEAR.
  - Else, only one valid: that requester's ready=1.
  - Else, both valid: the requester != last_grant gets ready=1, and last_grant updates to it.
  - At most one ready is high per cycle. Ready never asserts without its valid.
- Transfer and write timing:
  - A transfer occurs when valid&&ready.
  - Registered output on the next edge: fb_we=1, fb_addr=reqN_addr, fb_wdata={20'd0, reqN_data}. Latency is 1 cycle.
  - A cycle with no transfer gives fb_we=0 next cycle. fb_addr/fb_wdata hold their last value.
  - Requesters must hold addr/data stable while valid && !ready.
- CLEAR, with clear_start accepted in cycle T:
  - Colour is latched at T. clear_busy=1 in cycles T+1..T+FB_PIXELS (asserted iff state==CLEAR).
  - Each CLEAR cycle emits cnt, then cnt++. fb_we=1 with fb_addr=0 appears at T+2 and fb_addr=FB_PIXELS-1 at T+FB_PIXELS+1, with fb_wdata={20'd0, latched colour}.
  - On the edge emitting FB_PIXELS-1: state←ARB, cnt←0, clear_done pulses in cycle T+FB_PIXELS+1.
  - Both readys are 0 throughout CLEAR. clear_start during CLEAR is ignored; there is no restart.
  - Requester grants resume in cycle T+FB_PIXELS+1. last_grant is preserved across the clear.
  - A new clear_start in cycle T+FB_PIXELS+1 is accepted normally; ARB priority applies.
- Counter width: cnt is ADDR_W bits; it never reaches FB_PIXELS and wraps back to 0 explicitly.

Optional Feature:
- Macro FB_ARB_STATS_EN.
- When defined:
  - stat_grant0 and stat_grant1 increment on each req0/req1 transfer.
  - stat_stall increments each cycle where (req0_valid&&!req0_ready)||(req1_valid&&!req1_ready), including CLEAR cycles.
  - All three are 32-bit, wrap at 2^32, and are cleared by reset only.
- When undefined: the three stat ports are constant 0 and no counter logic is synthesised.

Test Plan:
- All tests use FB_PIXELS=16.
- Reset then idle: both valid=0 for 5 cycles → fb_we=0, fb_addr=0, fb_wdata=0, clear_busy=0.
- Single requester: req0 valid, addr=5, data=12'hF00 → req0_ready=1 the same cycle; next cycle fb_we=1, fb_addr=5, fb_wdata=32'h00000F00.
- Round-robin: both valid continuously for 4 cycles → grants req0,req1,req0,req1; fb_wdata alternates the two colours; never both ready.
- Clear: clear_start pulse at T with clear_colour=12'h0A5 while both requesters are valid → clear_busy high T+1..T+16; fb_addr 0..15 at T+2..T+17 with data 32'h000000A5; clear_done at T+17; readys resume at T+17.
- Abort/ignore: second clear_start at T+5 is ignored (addresses continue contiguously). Separately, reset at T+8 → next cycle fb_we=0, clear_busy=0, state ARB, and req0 is granted first.
- Stats (FB_ARB_STATS_EN defined): the round-robin test followed by the clear test → stat_grant0=2, stat_grant1=2, stat_stall counts every waiting-valid cycle (4 in round-robin, 17 in clear); without the macro all stat ports stay 0.
